// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full-adder slice per clock, LSB first.
// Subtraction inverts B bit-by-bit and seeds the carry with 1 (two's complement).
// Result, final carry and signed overflow are held in DONE until the consumer
// takes them with done_valid && done_ready.
module serial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sub_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             bi;
  logic             s;
  logic             carry_nxt;

  // Majority of three bits: carry out of a full adder.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Handshake/status outputs are decoded from the state register.
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // One-bit slice: conditional inverter on B feeding a full adder.
  assign bi        = b_sh[0] ^ sub_r;
  assign s         = a_sh[0] ^ bi ^ carry;
  assign carry_nxt = maj(a_sh[0], bi, carry);

  // Sequencer: accept, shift one bit per RUN cycle, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      sub_r      <= 1'b0;
      carry      <= 1'b0;
      cnt        <= '0;
      result     <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= sub;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry  <= carry_nxt;
          result <= {s, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // MSB slice: carry into it vs. carry out of it gives signed overflow.
            carry_out  <= carry_nxt;
            overflow   <= carry ^ carry_nxt;
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq (WIDTH=8) with an expected-result queue.
module tb_serial_addsub_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         done_valid;
  logic         done_ready;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   passes = 0;

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .sub(sub), .a(a), .b(b), .busy(busy), .result(result), .carry_out(carry_out),
    .overflow(overflow), .done_valid(done_valid), .done_ready(done_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference arithmetic, computed on whole words.
  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   full;
    logic [W-1:0] yy;
    exp_t         e;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.r  = full[W-1:0];
    e.c  = full[W];
    e.v  = (x[W-1] == yy[W-1]) && (e.r[W-1] != x[W-1]);
    return e;
  endfunction

  // Drive one request; returns one edge after acceptance (#1 past the edge).
  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    check("ready_before_issue", start_ready, 1'b1);
    start_valid = 1'b1;
    sub = s; a = x; b = y;
    @(posedge clk); #1;
    start_valid = 1'b0;
    sub = 1'bx; a = 'x; b = 'x;
    q.push_back(model(s, x, y));
  endtask

  // Wait (bounded) for done_valid, check latency, pop and compare.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (done_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, W);
    if (q.size() > 0) cur = q.pop_front();
    else cur = '0;
    check({tag, "_result"}, result, cur.r);
    check({tag, "_carry"}, carry_out, cur.c);
    check({tag, "_ovf"}, overflow, cur.v);
  endtask

  task automatic handshake(input string tag);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check({tag, "_dv_drop"}, done_valid, 1'b0);
    check({tag, "_ready_back"}, start_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    issue(s, x, y);
    wait_done(tag);
    handshake(tag);
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_carry", carry_out, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // done_ready with nothing pending must not disturb IDLE
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check("idle_done_ready", start_ready, 1'b1);

    run_op("add_35_0a", 1'b0, 8'h35, 8'h0A);
    check("add_35_0a_const", cur.r, 8'h3F);
    run_op("sub_10_01", 1'b1, 8'h10, 8'h01);
    run_op("sub_00_01", 1'b1, 8'h00, 8'h01);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01);
    run_op("sub_05_07", 1'b1, 8'h05, 8'h07);
    run_op("add_80_80", 1'b0, 8'h80, 8'h80);

    // Backpressure with a new request held throughout
    issue(1'b0, 8'h5A, 8'h21);
    check("bp_busy_run", busy, 1'b1);
    wait_done("bp_op");
    start_valid = 1'b1; sub = 1'b1; a = 8'h44; b = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_dv_hold", done_valid, 1'b1);
      check("bp_result_hold", result, cur.r);
      check("bp_not_ready", start_ready, 1'b0);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check("bp_dv_drop", done_valid, 1'b0);
    check("bp_no_same_cycle_accept", busy, 1'b0);
    check("bp_result_kept", result, cur.r);
    @(posedge clk); #1;
    check("bp_accept_next", busy, 1'b1);
    start_valid = 1'b0; sub = 1'bx; a = 'x; b = 'x;
    q.push_back(model(1'b1, 8'h44, 8'h11));
    wait_done("bp_next");
    handshake("bp_next");

    // Reset during RUN bit 3 aborts the operation
    issue(1'b0, 8'hC3, 8'h3C);
    void'(q.pop_back());
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_dv", done_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", start_ready, 1'b1);
    run_op("post_rst_add", 1'b0, 8'h01, 8'h01);
    check("post_rst_const", cur.r, 8'h02);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
